// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

  localparam int DEF_WORD_SIZE  = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] pc;
    logic [DEF_WORD_SIZE-1:0]  instr;
  } fetch_entry_t;

  // The occupancy counter must be able to hold the value DEPTH itself.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory port, the downstream stream and the
// redirect/halt controls of the fetch stage.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int CW = count_width(FIFO_DEPTH);

  logic                  imem_req_valid;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [WORD_SIZE-1:0]  imem_rdata;
  logic                  out_valid;
  logic [WORD_SIZE-1:0]  out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  out_ready;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  halt;
  logic [CW-1:0]         fetch_count;

  modport master (
    output imem_req_valid, imem_addr, out_valid, out_instr, out_pc, fetch_count,
    input  imem_rdata, out_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  imem_req_valid, imem_addr, out_valid, out_instr, out_pc, fetch_count,
    output imem_rdata, out_ready, redirect_valid, redirect_pc, halt
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous queue of fetched {pc, instr} entries; flush beats push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = DEF_FIFO_DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output entry_t        head
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  a_no_push_on_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited requests to a 1-cycle
// instruction memory and queues responses for the decode stage.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    WORD_SIZE  = DEF_WORD_SIZE,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_STEP    = 1
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int CW = count_width(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [WORD_SIZE-1:0]  instr;
  } entry_t;

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic                  rsp_pending;
  logic                  rsp_epoch;
  logic                  epoch;
  logic [CW-1:0]         count;
  entry_t                head;
  entry_t                push_data;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [CW:0]           credit_used;

  // A request is only issued if its response is guaranteed a queue slot.
  assign pop         = (count != '0) && bus.out_ready;
  assign credit_used = {1'b0, count} + (CW+1)'(rsp_pending) - (CW+1)'(pop);
  assign issue       = rst_n && (state == RUN) && !bus.halt && !bus.redirect_valid
                       && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign push        = rsp_pending && (rsp_epoch == epoch) && !bus.redirect_valid;
  assign push_data   = '{pc: rsp_pc, instr: bus.imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      rsp_pending <= 1'b0;
      rsp_pc      <= '0;
      rsp_epoch   <= 1'b0;
      epoch       <= 1'b0;
    end else begin
      case (state)
        RUN:     if (bus.halt)  state <= HALT;
        HALT:    if (!bus.halt) state <= RUN;
        default: state <= RUN;
      endcase
      rsp_pending <= issue;
      if (issue) begin
        rsp_pc    <= fetch_pc;
        rsp_epoch <= epoch;
      end
      // A redirect retargets the PC and marks anything older as stale.
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc;
        epoch    <= ~epoch;
      end else if (issue) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign bus.imem_req_valid = issue;
  assign bus.imem_addr      = fetch_pc;
  assign bus.out_valid      = (count != '0);
  assign bus.out_instr      = head.instr;
  assign bus.out_pc         = head.pc;
  assign bus.fetch_count    = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a queue-based model of the fetch
// rules, plus directed scenarios (streaming, stall, redirect, halt, wrap, reset).
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int AW    = 32;
  localparam int WS    = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [WS-1:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .FIFO_DEPTH(DEPTH)) bus ();
  fetch_unit_if #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .FIFO_DEPTH(DEPTH)) wbus ();

  fetch_unit #(
    .WORD_SIZE(WS), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000), .PC_STEP(32'd1)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  fetch_unit #(
    .WORD_SIZE(WS), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
    .RESET_PC(32'hFFFF_FFFE), .PC_STEP(32'd1)
  ) dut_wrap (.clk(clk), .rst_n(rst_n), .bus(wbus));

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference state: what has been fetched and not yet consumed, what is in flight.
  ent_t          mq[$];
  logic [AW-1:0] m_pc;
  bit            m_inflight;
  logic [AW-1:0] m_inflight_pc;
  bit            m_halt_prev;

  // Memory model state: request the DUT actually made last cycle.
  bit            rec_valid;
  logic [AW-1:0] rec_addr;
  bit            wrec_valid;
  logic [AW-1:0] wrec_addr;

  function automatic logic [WS-1:0] memWord(input logic [AW-1:0] a);
    return WS'(32'h1000 + a);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_pc          = '0;
    m_inflight    = 1'b0;
    m_inflight_pc = '0;
    m_halt_prev   = 1'b0;
    rec_valid     = 1'b0;
    wrec_valid    = 1'b0;
  endtask

  task automatic applyStimulus(input bit rdy, input bit redir,
                               input logic [AW-1:0] rpc, input bit hlt);
    bus.out_ready      = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.halt           = hlt;
    bus.imem_rdata     = rec_valid  ? memWord(rec_addr)  : WS'($urandom());
    wbus.imem_rdata    = wrec_valid ? memWord(wrec_addr) : WS'($urandom());
  endtask

  task automatic compareRegistered();
    checkOutput("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    checkOutput("fetch_count", 64'(bus.fetch_count), 64'(mq.size()));
    if (mq.size() != 0) begin
      checkOutput("out_pc", 64'(bus.out_pc), 64'(mq[0].pc));
      checkOutput("out_instr", 64'(bus.out_instr), 64'(mq[0].instr));
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic stepCycle(input bit rdy, input bit redir,
                           input logic [AW-1:0] rpc, input bit hlt);
    bit   pop;
    bit   issue;
    int   used;
    ent_t e;
    compareRegistered();
    applyStimulus(rdy, redir, rpc, hlt);
    #1;
    pop   = (mq.size() != 0) && rdy;
    used  = mq.size() + int'(m_inflight) - int'(pop);
    issue = !m_halt_prev && !hlt && !redir && (used < DEPTH);
    checkOutput("imem_req_valid", 64'(bus.imem_req_valid), 64'(issue));
    if (issue) checkOutput("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
    rec_valid  = bus.imem_req_valid;
    rec_addr   = bus.imem_addr;
    wrec_valid = wbus.imem_req_valid;
    wrec_addr  = wbus.imem_addr;
    if (redir) begin
      mq.delete();
      m_pc       = rpc;
      m_inflight = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_inflight) begin
        e.pc    = m_inflight_pc;
        e.instr = memWord(m_inflight_pc);
        mq.push_back(e);
      end
      m_inflight = issue;
      if (issue) begin
        m_inflight_pc = m_pc;
        m_pc          = m_pc + 1;
      end
    end
    m_halt_prev = hlt;
    @(negedge clk);
  endtask

  initial begin
    bit            r_rdy;
    bit            r_redir;
    bit            r_hlt;
    logic [AW-1:0] r_pc;

    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.halt            = 1'b0;
    bus.imem_rdata      = '0;
    wbus.out_ready      = 1'b1;
    wbus.redirect_valid = 1'b0;
    wbus.redirect_pc    = '0;
    wbus.halt           = 1'b0;
    wbus.imem_rdata     = '0;
    modelReset();

    repeat (3) @(negedge clk);
    checkOutput("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    checkOutput("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_instr", 64'(bus.out_instr), 64'd0);
    checkOutput("rst_out_pc", 64'(bus.out_pc), 64'd0);
    checkOutput("rst_fetch_count", 64'(bus.fetch_count), 64'd0);
    rst_n = 1'b1;

    // Streaming with the consumer always ready.
    stepCycle(1, 0, '0, 0);
    stepCycle(1, 0, '0, 0);
    checkOutput("stream_pc0", 64'(bus.out_pc), 64'd0);
    checkOutput("stream_instr0", 64'(bus.out_instr), 64'h1000);
    checkOutput("wrap_pc0", 64'(wbus.out_pc), 64'hFFFF_FFFE);
    stepCycle(1, 0, '0, 0);
    checkOutput("stream_pc1", 64'(bus.out_pc), 64'd1);
    checkOutput("stream_instr1", 64'(bus.out_instr), 64'h1001);
    checkOutput("wrap_pc1", 64'(wbus.out_pc), 64'hFFFF_FFFF);
    stepCycle(1, 0, '0, 0);
    checkOutput("stream_pc2", 64'(bus.out_pc), 64'd2);
    checkOutput("wrap_pc2", 64'(wbus.out_pc), 64'h0);
    checkOutput("wrap_instr2", 64'(wbus.out_instr), 64'h1000);
    checkOutput("wrap_valid2", 64'(wbus.out_valid), 64'd1);
    repeat (12) stepCycle(1, 0, '0, 0);

    // Back-pressure: queue fills and requests stop.
    repeat (10) stepCycle(0, 0, '0, 0);
    checkOutput("stall_count", 64'(bus.fetch_count), 64'd2);
    checkOutput("stall_req", 64'(bus.imem_req_valid), 64'd0);
    repeat (6) stepCycle(1, 0, '0, 0);

    // Redirect with a full queue.
    repeat (4) stepCycle(0, 0, '0, 0);
    stepCycle(1, 1, 32'h40, 0);
    checkOutput("redir_flush_t1", 64'(bus.out_valid), 64'd0);
    stepCycle(1, 0, '0, 0);
    checkOutput("redir_flush_t2", 64'(bus.out_valid), 64'd0);
    stepCycle(1, 0, '0, 0);
    checkOutput("redir_valid_t3", 64'(bus.out_valid), 64'd1);
    checkOutput("redir_pc_t3", 64'(bus.out_pc), 64'h40);
    checkOutput("redir_instr_t3", 64'(bus.out_instr), 64'h1040);
    repeat (3) stepCycle(1, 0, '0, 0);
    stepCycle(1, 1, 32'h80, 0);
    stepCycle(1, 1, 32'h90, 0);
    repeat (4) stepCycle(1, 0, '0, 0);

    // Halt for five cycles, then resume.
    repeat (5) stepCycle(0, 0, '0, 1);
    checkOutput("halt_req", 64'(bus.imem_req_valid), 64'd0);
    repeat (8) stepCycle(1, 0, '0, 0);

    // Random mix of back-pressure, halts and redirects.
    r_hlt = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      r_rdy   = ($urandom_range(0, 99) < 70);
      r_redir = ($urandom_range(0, 99) < 6);
      r_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + AW'($urandom_range(0, 3))
                                            : AW'($urandom());
      if ($urandom_range(0, 99) < 12) r_hlt = ~r_hlt;
      stepCycle(r_rdy, r_redir, r_pc, r_hlt);
    end

    // Asynchronous reset with a full queue.
    repeat (4) stepCycle(0, 0, '0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("arst_fetch_count", 64'(bus.fetch_count), 64'd0);
    checkOutput("arst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stepCycle(1, 0, '0, 0);
    stepCycle(1, 0, '0, 0);
    checkOutput("arst_restart_pc", 64'(bus.out_pc), 64'd0);
    repeat (6) stepCycle(1, 0, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decode/control path; it owns the fetch PC.
- Issues word addresses to a synchronous instruction memory with a fixed 1-cycle read latency.
- Buffers returned instructions with their PCs in a small queue and presents them downstream through a valid/ready handshake.
- Supports branch redirect with flush and discard of stale responses, plus a halt/resume control.

Parameters:
- WORD_SIZE, 32, instruction width in bits.
- ADDR_WIDTH, 32, fetch PC and memory address width in bits.
- FIFO_DEPTH, 2, instruction queue entries; minimum 2, power of two.
- RESET_PC, 0, fetch PC loaded on reset.
- PC_STEP, 1, PC increment per fetch; memory is word-addressed.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  address is valid this cycle.
- imem_addr  out  ADDR_WIDTH  fetch address.
- imem_rdata  in  WORD_SIZE  instruction data for the request issued in the previous cycle.
- out_valid  out  1  queue head is valid.
- out_instr  out  WORD_SIZE  head instruction.
- out_pc  out  ADDR_WIDTH  PC of the head instruction.
- out_ready  in  1  consumer accepts the head.
- redirect_valid  in  1  branch taken; flush and restart.
- redirect_pc  in  ADDR_WIDTH  new fetch target.
- halt  in  1  stop issuing new requests.
- fetch_count  out  $clog2(FIFO_DEPTH)+1  queue occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, queue empty, rsp_pending=0, epoch=0, state=RUN.
  - Outputs: imem_req_valid=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetch_count=0.
  - Reset asserted mid-operation discards all queued and in-flight data immediately.
- FSM states: RUN, HALT.
  - RUN→HALT when halt=1.
  - HALT→RUN when halt=0.
  - In HALT no requests are issued. An in-flight response is still captured, and the queue drains normally.
- Issue rule, evaluated combinationally:
  - pop = out_valid & out_ready.
  - imem_req_valid = (state==RUN) & ~halt & ~redirect_valid & ((count + rsp_pending − pop) < FIFO_DEPTH).
  - On issue: imem_addr=fetch_pc; fetch_pc += PC_STEP modulo 2^ADDR_WIDTH (wraps from all-ones to 0); rsp_pending<=1; rsp_pc<=fetch_pc; rsp_epoch<=epoch.
  - With no issue, rsp_pending<=0.
- Response capture:
  - When rsp_pending=1, imem_rdata is sampled this cycle.
  - It is pushed as {rsp_pc, imem_rdata} only if rsp_epoch==epoch and redirect_valid=0; otherwise it is dropped.
  - The credit rule guarantees a push never meets a full queue; push-on-full is an assertion failure.
- Output: out_valid/out_instr/out_pc are the registered queue head. A push into an empty queue appears the next cycle.
- Latency and throughput:
  - Request in cycle T, data in T+1, out_valid in T+2.
  - Sustained throughput is 1 instruction/cycle with out_ready=1 and FIFO_DEPTH≥2.
- Simultaneous push and pop: count unchanged, order preserved.
- Redirect (priority over everything except reset):
  - In cycle T: the head handshake, if out_ready=1, still counts as consumed (the branch itself).
  - Then the queue is fully flushed, epoch toggles, fetch_pc<=redirect_pc, and no request is issued in T.
  - The first request to redirect_pc is in T+1 if RUN and halt=0.
- Redirect while HALT: PC updated and queue flushed; state stays HALT.
- Back-to-back redirects: the last one wins. Each toggles the epoch; no stale data is ever pushed.
- out_ready=0 with a full queue: no issue, PC holds, outputs stable (AXI-style stability).

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {RUN, HALT}.
  - The fetch_entry_t struct {pc, instr}.
  - Default width constants.
- One sub-module, fetch_fifo: parameterised synchronous queue of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - flush takes priority over push.
  - Asynchronous active-low reset.
- The issue/credit logic and epoch tracking stay in fetch_unit.

Test Plan:
- Reset release, out_ready=1, imem returns 0x1000+addr → out_pc 0,1,2,3… on consecutive cycles from cycle 2; out_instr 0x1000,0x1001…; no gaps.
- out_ready=0 for 10 cycles → fetch_count saturates at 2; imem_req_valid=0; out_pc held at 0; release → 0,1,2 resume in order with no loss or duplication.
- redirect_valid with redirect_pc=0x40 while an issue is in flight and the queue is full → the stale response is dropped; next out_pc=0x40 appears 3 cycles after the redirect; no old-path PC is ever emitted.
- halt=1 for 5 cycles → at most one more instruction enters the queue; no requests are issued; halt=0 → fetch resumes at the next sequential PC.
- RESET_PC=32'hFFFF_FFFE, out_ready=1 → out_pc sequence FFFF_FFFE, FFFF_FFFF, 0000_0000.
- rst asserted mid-stream with the queue full → out_valid=0 and fetch_count=0 immediately (asynchronously); after release, fetch restarts at RESET_PC.
